// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and RAM-side signals of the memory port arbiter.
// The arbiter uses the slave view; the core/RAM side uses the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the fetch and data ports, one access at a time,
// with data priority, fetch anti-starvation and a memory-mapped LED toggle register.
module mem_port_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter int                RD_LATENCY  = 1,
    parameter int                MAX_STARVE  = 4,
    parameter logic [ADDR_W-1:0] TOGGLE_ADDR = ADDR_W'(52)
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus,
    output logic [31:0]       toggle_value,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam int            SW         = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(MAX_STARVE);
    localparam logic [2:0]    LAT_LOAD   = 3'(RD_LATENCY - 1);

    state_e            state_q, state_d;
    logic              winIsD_q, winIsD_d;
    logic              isToggle_q, isToggle_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        lat_q, lat_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [31:0]       toggle_q, toggle_d;

    logic anyReq;
    logic arbitrate;
    logic iWins;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            winIsD_q   <= 1'b0;
            isToggle_q <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'b0;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
            lat_q      <= 3'b0;
            starve_q   <= '0;
            toggle_q   <= 32'b0;
        end else begin
            state_q    <= state_d;
            winIsD_q   <= winIsD_d;
            isToggle_q <= isToggle_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            toggle_q   <= toggle_d;
        end
    end

    // Fetch is forced to win once it has lost MAX_STARVE arbitrations in a row.
    always_comb begin
        anyReq    = bus.i_req | bus.d_req;
        arbitrate = (state_q == IDLE) || (state_q == RESP);
        iWins     = bus.i_req &&
                    (!bus.d_req || ((MAX_STARVE > 0) && (starve_q == STARVE_TOP)));
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        unique case (state_q)
            IDLE, RESP: state_d = anyReq ? ISSUE : IDLE;
            ISSUE: begin
                lat_d   = LAT_LOAD;
                state_d = (RD_LATENCY > 1) ? WAIT : RESP;
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        winIsD_d   = winIsD_q;
        isToggle_d = isToggle_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        toggle_d   = toggle_q;

        if (arbitrate && anyReq) begin
            winIsD_d = !iWins;
            if (iWins) begin
                isToggle_d = 1'b0;
                we_d       = 1'b0;
                be_d       = 4'b0;
                addr_d     = bus.i_addr;
                wdata_d    = 32'b0;
                starve_d   = '0;
            end else begin
                isToggle_d = (bus.d_addr == TOGGLE_ADDR);
                we_d       = bus.d_we;
                be_d       = bus.d_be;
                addr_d     = bus.d_addr;
                wdata_d    = bus.d_wdata;
                if (bus.i_req && (starve_q != STARVE_TOP)) starve_d = starve_q + 1'b1;
            end
        end

        // Toggle-register writes land on the edge that ends the ISSUE cycle.
        if ((state_q == ISSUE) && winIsD_q && isToggle_q && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) toggle_d[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        bus.i_gnt     = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.i_rdata   = 32'b0;
        bus.d_rdata   = 32'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;

        if (state_q == ISSUE) begin
            bus.i_gnt  = !winIsD_q;
            bus.d_gnt  = winIsD_q;
            bus.mem_en = !isToggle_q;
            if (winIsD_q && we_q && !isToggle_q) bus.mem_we = be_q;
        end

        if (state_q == RESP) begin
            if (winIsD_q) begin
                bus.d_rvalid = 1'b1;
                if (!we_q) bus.d_rdata = isToggle_q ? toggle_q : bus.mem_rdata;
            end else begin
                bus.i_rvalid = 1'b1;
                bus.i_rdata  = bus.mem_rdata;
            end
        end

        toggle_value = toggle_q;
        busy         = (state_q != IDLE);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port block RAM between the fetch stage (I-port, read-only) and the memory stage (D-port, read/write) of the pipelined RISC-V core. Each port uses a req/gnt/rvalid handshake. The block runs a small FSM that issues one RAM access at a time and waits out the RAM read latency. It also owns the memory-mapped LED toggle register.
Data requests have priority, and an anti-starvation counter guarantees that fetch makes forward progress.

Parameters:
ADDR_W, 32, width of all byte addresses (passed to RAM unmodified)
RD_LATENCY, 1, RAM read latency in cycles from the mem_en edge to valid mem_rdata (legal 1..4)
MAX_STARVE, 4, number of consecutive arbitrations the I-port may lose before it is forced to win; 0 = strict D priority
TOGGLE_ADDR, 32'd52, D-port address of the toggle register

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  reset, synchronous, active-low
i_req  in  1  fetch request
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch request accepted (1-cycle pulse)
i_rvalid  out  1  fetch data valid (1-cycle pulse)
i_rdata  out  32  fetch data
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read
d_be  in  4  byte enables for writes
d_addr  in  ADDR_W  data address
d_wdata  in  32  write data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  data completion / read data valid (1-cycle pulse)
d_rdata  out  32  read data
mem_en  out  1  RAM enable
mem_we  out  4  RAM byte write enables
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data
toggle_value  out  32  LED toggle register
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is resetn, synchronous and active-low.
- Reset values (applied at any edge with resetn=0, including mid-transaction):
  - state=IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All gnt/rvalid outputs = 0; toggle_value=0; starve counter=0; latency counter=0.
  - An in-flight access is dropped with no rvalid.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Arbitration: requests are sampled only in IDLE and RESP.
  - Winner is D if d_req, unless i_req and starve_cnt==MAX_STARVE (MAX_STARVE>0), in which case the winner is I.
  - If only one port requests, that port wins.
  - Winner's addr, we, be and wdata are latched into the mem_* registers.
  - Next state is ISSUE.
- Starve counter:
  - Increments when i_req=1 and D wins.
  - Clears when I wins.
  - Saturates at MAX_STARVE.
- ISSUE (1 cycle): the winner's gnt is high.
  - mem_en=1 for a RAM access; mem_we=d_be for a D write, 0 otherwise.
  - The requester may change or drop req from the next cycle.
  - Next state is WAIT if RD_LATENCY>1 (latency counter loaded with RD_LATENCY-1), else RESP.
- WAIT: mem_en=0, mem_we=0; counter decrements; go to RESP when it reaches 1.
- RESP (1 cycle): winner's rvalid=1.
  - Read: rdata = mem_rdata (combinational pass-through).
  - Write: rdata = 0.
  - The other port's rvalid and rdata are 0.
  - Arbitrate again; next state is ISSUE if any req, else IDLE.
- Timing: req sampled at edge T gives gnt in cycle T+1 and rvalid in cycle T+1+RD_LATENCY. Back-to-back throughput is one access per RD_LATENCY+1 cycles.
- Toggle register: D access with d_addr==TOGGLE_ADDR.
  - No RAM access: mem_en=0 and mem_we=0 in ISSUE.
  - Same FSM timing as a RAM access.
  - Write: toggle_value updates at the ISSUE edge using d_be byte masking.
  - Read: d_rdata=toggle_value in RESP.
- I-port: never writes and never decodes TOGGLE_ADDR.
- A req held high across RESP is treated as a new request.

Test Plan:
1. RD_LATENCY=1: i_req with i_addr=0x10, mem_rdata=0xDEADBEEF → i_gnt in cycle 1 with mem_en=1 and mem_addr=0x10; i_rvalid in cycle 2 with i_rdata=0xDEADBEEF; busy 0 in cycle 3.
2. i_req and d_req (read, 0x40) rise in the same cycle → d_gnt first; i_gnt in the ISSUE cycle following d_rvalid; each port's rvalid carries only its own data.
3. MAX_STARVE=4, d_req and i_req both held high → grant order D,D,D,D,I,D…; starve count never exceeds 4. MAX_STARVE=0 → I is never granted while d_req=1.
4. D write, d_addr=52, d_wdata=0xA5, d_be=4'hF → mem_en stays 0; toggle_value=0xA5 from the following cycle. Then D read of 52 → d_rdata=0xA5. Then write 0x1234_5678 with d_be=4'b0010 → toggle_value=0x0000_56A5.
5. D write, addr 0x20, d_wdata=0xCAFEBABE, d_be=4'b0011 → ISSUE: mem_we=4'b0011, mem_wdata=0xCAFEBABE, mem_addr=0x20; d_rvalid next cycle with d_rdata=0.
6. RD_LATENCY=3, resetn=0 for one cycle while in WAIT → next cycle: all outputs at reset values, no rvalid ever issued for the dropped access. A fresh i_req after reset completes normally with rvalid 4 cycles after the req edge.
